// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one programmable bit-pattern matcher
// across NCH serial channels, keeping per-channel history and bit counts.
module seq_detect_scheduler #(
    parameter int unsigned     NCH         = 4,
    parameter int unsigned     PMAX        = 8,
    parameter logic [PMAX-1:0] DEF_PATTERN = 8'h06,
    parameter int unsigned     DEF_LEN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [PMAX-1:0]            cfg_pattern,
    input  logic [$clog2(PMAX+1)-1:0]  cfg_len,
    input  logic [NCH-1:0]             in_valid,
    input  logic [NCH-1:0]             in_bit,
    output logic [NCH-1:0]             in_ready,
    output logic                       match_valid,
    output logic [$clog2(NCH)-1:0]     match_ch,
    output logic [$clog2(PMAX+1)-1:0]  cfg_len_q
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned LW = $clog2(PMAX+1);

    logic [PMAX-1:0] r_hist [NCH];
    logic [LW-1:0]   r_cnt  [NCH];
    logic [PMAX-1:0] r_pattern;
    logic [LW-1:0]   r_len;
    logic [CW-1:0]   r_rr_ptr;
    logic            r_match_valid;
    logic [CW-1:0]   r_match_ch;

    logic            w_gnt_any;
    logic [CW-1:0]   w_gnt_idx;
    logic            w_fire;
    logic            w_cfg_ok;
    logic [PMAX-1:0] w_mask;
    logic [PMAX-1:0] w_new_hist;
    logic [LW-1:0]   w_new_cnt;
    logic            w_match;
    logic [NCH-1:0]  w_ready;

    // Channel index reached by stepping 'off' positions from 'base', modulo NCH.
    function automatic logic [CW-1:0] f_wrap_idx(input logic [CW-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NCH) begin
            sum = sum - NCH;
        end
        return CW'(sum);
    endfunction

    // Round-robin search for the first valid channel starting at r_rr_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < int'(NCH); k++) begin
            if (!w_gnt_any && in_valid[f_wrap_idx(r_rr_ptr, 32'(k))]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = f_wrap_idx(r_rr_ptr, 32'(k));
            end else begin
                w_gnt_any = w_gnt_any;
            end
        end
    end

    // Configuration writes and reset both stall the arbiter for the cycle.
    always_comb begin
        w_fire   = w_gnt_any & ~cfg_we & ~rst;
        w_cfg_ok = cfg_we && (cfg_len != '0) && (cfg_len <= LW'(PMAX));
        w_ready  = '0;
        if (w_fire) begin
            w_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_ready = '0;
        end
    end

    // Mask of the active pattern length, LSB-aligned.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(PMAX); i++) begin
            w_mask[i] = (LW'(i) < r_len);
        end
    end

    // Post-update history/count of the granted channel and the match decision.
    always_comb begin
        w_new_hist = {r_hist[w_gnt_idx][PMAX-2:0], in_bit[w_gnt_idx]};
        if (r_cnt[w_gnt_idx] == LW'(PMAX)) begin
            w_new_cnt = r_cnt[w_gnt_idx];
        end else begin
            w_new_cnt = r_cnt[w_gnt_idx] + LW'(1);
        end
        w_match = w_fire
                  && ((w_new_hist & w_mask) == (r_pattern & w_mask))
                  && (w_new_cnt >= r_len);
    end

    // Channel state, configuration, arbiter pointer and registered match outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_hist[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_pattern     <= DEF_PATTERN;
            r_len         <= LW'(DEF_LEN);
            r_rr_ptr      <= '0;
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
        end else if (w_cfg_ok) begin
            for (int i = 0; i < int'(NCH); i++) begin
                r_hist[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_pattern     <= cfg_pattern;
            r_len         <= cfg_len;
            r_match_valid <= 1'b0;
        end else if (w_fire) begin
            r_hist[w_gnt_idx] <= w_new_hist;
            r_cnt[w_gnt_idx]  <= w_new_cnt;
            r_rr_ptr          <= f_wrap_idx(w_gnt_idx, 32'd1);
            r_match_valid     <= w_match;
            if (w_match) begin
                r_match_ch <= w_gnt_idx;
            end else begin
                r_match_ch <= r_match_ch;
            end
        end else begin
            r_match_valid <= 1'b0;
        end
    end

    assign in_ready    = w_ready;
    assign match_valid = r_match_valid;
    assign match_ch    = r_match_ch;
    assign cfg_len_q   = r_len;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed self-checking bench for seq_detect_scheduler (NCH=4, PMAX=8).
module tb_seq_detect_scheduler;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [3:0] in_valid;
    logic [3:0] in_bit;
    logic [3:0] in_ready;
    logic       match_valid;
    logic [1:0] match_ch;
    logic [3:0] cfg_len_q;

    int n_checks = 0;
    int n_errors = 0;

    seq_detect_scheduler #(
        .NCH(4), .PMAX(8), .DEF_PATTERN(8'h06), .DEF_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .match_valid(match_valid), .match_ch(match_ch),
        .cfg_len_q(cfg_len_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at negedge, check in_ready, then check registered match after posedge.
    task automatic tick(input logic [3:0] v, input logic [3:0] b, input logic we,
                        input logic r, input logic [3:0] exp_rdy, input logic exp_mv,
                        input logic [1:0] exp_ch, input string tag);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cfg_we   = we;
        rst      = r;
        #1;
        chk({tag, ".rdy"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, ".mv"}, 32'(match_valid), 32'(exp_mv));
        if (exp_mv) chk({tag, ".ch"}, 32'(match_ch), 32'(exp_ch));
    endtask

    logic [3:0] s0110;
    logic [7:0] pa5;

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0;
        in_valid = 4'h0; in_bit = 4'h0;
        s0110 = 4'b0110;
        pa5   = 8'hA5;

        // Reset state
        tick(4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, "rst0");
        tick(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, "rst1");
        chk("rst.ch",  32'(match_ch), 32'd0);
        chk("rst.len", 32'(cfg_len_q), 32'd4);

        // T1: ch0 0,1,1,0
        tick(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t1b0");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t1b1");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t1b2");
        tick(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, "t1b3");
        tick(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, "t1idle");

        // T2: ch1 0110110, overlapping matches after bits 4 and 7
        tick(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, "t2b0");
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, "t2b1");
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, "t2b2");
        tick(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, "t2b3");
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, "t2b4");
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, "t2b5");
        tick(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, "t2b6");
        tick(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1, "t2idle");

        // T3: fresh reset, ch0 and ch2 both stream 0110 and alternate
        tick(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 2'd0, "t3rst");
        for (int k = 0; k < 8; k++) begin
            logic [3:0] b;
            b = 4'h0;
            if (k % 2 == 0) b[0] = s0110[k/2];
            else            b[2] = s0110[k/2];
            tick(4'h5, b, 1'b0, 1'b0, (k % 2 == 0) ? 4'h1 : 4'h4,
                 (k >= 6) ? 1'b1 : 1'b0, (k == 6) ? 2'd0 : 2'd2, "t3");
        end
        tick(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2, "t3idle");

        // T4: 011 on ch0, then load pattern 101 len 3, then 0,1,0,1
        tick(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4p0");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4p1");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4p2");
        cfg_pattern = 8'h05; cfg_len = 4'd3;
        tick(4'h1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, "t4cfg");
        chk("t4.len", 32'(cfg_len_q), 32'd3);
        tick(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4b0");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4b1");
        tick(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 2'd0, "t4b2");
        tick(4'h1, 4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 2'd0, "t4b3");

        // T5: illegal len=0 write mid-stream on ch1 is ignored
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 2'd0, "t5b0");
        tick(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 1'b0, 2'd0, "t5b1");
        cfg_pattern = 8'hFF; cfg_len = 4'd0;
        tick(4'h2, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, "t5cfg");
        chk("t5.len", 32'(cfg_len_q), 32'd3);
        tick(4'h2, 4'h2, 1'b0, 1'b0, 4'h2, 1'b1, 2'd1, "t5b2");

        // T6: rst after 011 on ch3 discards history and restores defaults
        tick(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 1'b0, 2'd0, "t6b0");
        tick(4'h8, 4'h8, 1'b0, 1'b0, 4'h8, 1'b0, 2'd0, "t6b1");
        tick(4'h8, 4'h8, 1'b0, 1'b0, 4'h8, 1'b0, 2'd0, "t6b2");
        cfg_pattern = 8'h05; cfg_len = 4'd3;
        tick(4'h8, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 2'd0, "t6rst");
        chk("t6.ch",  32'(match_ch), 32'd0);
        chk("t6.len", 32'(cfg_len_q), 32'd4);
        tick(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 1'b0, 2'd0, "t6b3");

        // T7: illegal len>PMAX ignored, then len=PMAX needs 8 bits
        cfg_pattern = 8'hFF; cfg_len = 4'd9;
        tick(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, "t7bad");
        chk("t7.len9", 32'(cfg_len_q), 32'd4);
        cfg_pattern = 8'hA5; cfg_len = 4'd8;
        tick(4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, "t7cfg");
        chk("t7.len8", 32'(cfg_len_q), 32'd8);
        for (int k = 7; k >= 0; k--) begin
            tick(4'h1, {3'b000, pa5[k]}, 1'b0, 1'b0, 4'h1,
                 (k == 0) ? 1'b1 : 1'b0, 2'd0, "t7");
        end
        tick(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, "t7idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
